// File: rtl/booth_multiplier_seq.sv
// Sequential radix-4 Booth multiplier: retires two multiplier bits per clock
// and returns the full 2*WIDTH-bit signed or unsigned product as HI/LO halves.
module booth_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CNT_W = $clog2(WIDTH/2+2);
  localparam int K     = WIDTH/2 + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH+2:0] acc;
  logic [WIDTH+2:0] mreg;
  logic [WIDTH+1:0] qreg;
  logic             qm1;
  logic [CNT_W-1:0] cnt;

  logic [2:0]       triplet;
  logic [WIDTH+2:0] addend;
  logic [WIDTH+2:0] sum;
  logic [WIDTH+2:0] acc_next;
  logic [WIDTH+1:0] q_next;

  // One recode step: add the selected multiple of M, then arithmetic shift {A,Q,Q[-1]} by two.
  always_comb begin
    triplet = {qreg[1:0], qm1};
    addend  = '0;
    case (triplet)
      3'b001, 3'b010: addend = mreg;
      3'b011:         addend = mreg << 1;
      3'b100:         addend = -(mreg << 1);
      3'b101, 3'b110: addend = -mreg;
      default:        addend = '0;
    endcase
    sum      = acc + addend;
    acc_next = {{2{sum[WIDTH+2]}}, sum[WIDTH+2:2]};
    q_next   = {sum[1:0], qreg[WIDTH+1:2]};
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state      <= IDLE;
      acc        <= '0;
      mreg       <= '0;
      qreg       <= '0;
      qm1        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Extending to WIDTH+2 bits lets the same signed datapath handle unsigned operands.
            mreg  <= is_signed ? {{3{m[WIDTH-1]}}, m} : {3'b000, m};
            qreg  <= is_signed ? {{2{q[WIDTH-1]}}, q} : {2'b00, q};
            acc   <= '0;
            qm1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= acc_next;
          qreg <= q_next;
          qm1  <= qreg[1];
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(K-1)) begin
            product_hi <= {acc_next[WIDTH-3:0], q_next[WIDTH+1:WIDTH]};
            product_lo <= q_next[WIDTH-1:0];
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed-vector bench for booth_multiplier_seq: a 32-bit and an 8-bit instance
// checked against hand-computed products, latency, overlap and async abort.
module tb_booth_multiplier_seq;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        start32, sgn32;
  logic [31:0] q32, m32;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;
  logic        start8, sgn8;
  logic [7:0]  q8, m8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  booth_multiplier_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .clear_n(clear_n), .start(start32), .is_signed(sgn32),
    .q(q32), .m(m32), .busy(busy32), .done(done32),
    .product_hi(hi32), .product_lo(lo32)
  );

  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .clear_n(clear_n), .start(start8), .is_signed(sgn8),
    .q(q8), .m(m8), .busy(busy8), .done(done8),
    .product_hi(hi8), .product_lo(lo8)
  );

  // Stimulus only: issues one 32-bit request and waits (bounded) for done.
  task automatic run32(input logic [31:0] qv, input logic [31:0] mv, input logic sv,
                       output int edges, output int busy_cycles);
    repeat (2) @(posedge clock);
    @(negedge clock);
    q32 = qv; m32 = mv; sgn32 = sv; start32 = 1'b1;
    @(posedge clock); #1;
    start32 = 1'b0;
    edges = 0;
    busy_cycles = busy32 ? 1 : 0;
    while (!done32 && edges < 40) begin
      @(posedge clock); #1;
      edges++;
      if (busy32) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0;
    start32 = 1'b0; sgn32 = 1'b0; q32 = '0; m32 = '0;
    start8 = 1'b0; sgn8 = 1'b0; q8 = '0; m8 = '0;
    #12;
    checks++;
    if ({busy32, done32, hi32, lo32} !== 66'd0) begin
      errors++;
      $display("[TB] FAIL reset32: got busy=%b done=%b hi=%h lo=%h expected all zero", busy32, done32, hi32, lo32);
    end
    checks++;
    if ({busy8, done8, hi8, lo8} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset8: got busy=%b done=%b hi=%h lo=%h expected all zero", busy8, done8, hi8, lo8);
    end
    @(negedge clock);
    clear_n = 1'b1;
  endtask

  task automatic test_signed_small();
    int e, b;
    run32(32'hFFFFFFF9, 32'd6, 1'b1, e, b);
    checks++;
    if (e !== 17) begin errors++; $display("[TB] FAIL neg7x6 latency: got %0d expected 17", e); end
    checks++;
    if (b !== 17) begin errors++; $display("[TB] FAIL neg7x6 busy cycles: got %0d expected 17", b); end
    checks++;
    if (hi32 !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL neg7x6 hi: got %h expected ffffffff", hi32); end
    checks++;
    if (lo32 !== 32'hFFFFFFD6) begin errors++; $display("[TB] FAIL neg7x6 lo: got %h expected ffffffd6", lo32); end
    @(posedge clock); #1;
    checks++;
    if (done32 !== 1'b0) begin errors++; $display("[TB] FAIL done pulse width: got %b expected 0", done32); end
  endtask

  task automatic test_all_ones();
    int e, b;
    run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, e, b);
    checks++;
    if ({hi32, lo32} !== 64'hFFFFFFFE_00000001) begin
      errors++; $display("[TB] FAIL ones unsigned: got %h_%h expected fffffffe_00000001", hi32, lo32);
    end
    run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, e, b);
    checks++;
    if ({hi32, lo32} !== 64'h00000000_00000001) begin
      errors++; $display("[TB] FAIL ones signed: got %h_%h expected 00000000_00000001", hi32, lo32);
    end
  endtask

  task automatic test_most_negative();
    int e, b;
    run32(32'h80000000, 32'h80000000, 1'b1, e, b);
    checks++;
    if ({hi32, lo32} !== 64'h40000000_00000000) begin
      errors++; $display("[TB] FAIL minneg squared: got %h_%h expected 40000000_00000000", hi32, lo32);
    end
    run32(32'h0, 32'h12345678, 1'b1, e, b);
    checks++;
    if ({hi32, lo32} !== 64'd0) begin
      errors++; $display("[TB] FAIL zero times: got %h_%h expected 0", hi32, lo32);
    end
    run32(32'h80000000, 32'd2, 1'b0, e, b);
    checks++;
    if ({hi32, lo32} !== 64'h00000001_00000000) begin
      errors++; $display("[TB] FAIL 2^31x2 unsigned: got %h_%h expected 00000001_00000000", hi32, lo32);
    end
    run32(32'h80000000, 32'd2, 1'b1, e, b);
    checks++;
    if ({hi32, lo32} !== 64'hFFFFFFFF_00000000) begin
      errors++; $display("[TB] FAIL minneg x2 signed: got %h_%h expected ffffffff_00000000", hi32, lo32);
    end
  endtask

  task automatic test_width8();
    int e;
    repeat (2) @(posedge clock);
    @(negedge clock);
    q8 = 8'h80; m8 = 8'h7F; sgn8 = 1'b1; start8 = 1'b1;
    @(posedge clock); #1;
    start8 = 1'b0;
    e = 0;
    while (!done8 && e < 40) begin
      @(posedge clock); #1;
      e++;
    end
    checks++;
    if (e !== 5) begin errors++; $display("[TB] FAIL w8 latency: got %0d expected 5", e); end
    checks++;
    if ({hi8, lo8} !== 16'hC080) begin errors++; $display("[TB] FAIL w8 product: got %h_%h expected c0_80", hi8, lo8); end
  endtask

  task automatic test_back_to_back();
    int e, pulses;
    repeat (2) @(posedge clock);
    @(negedge clock);
    q32 = 32'd3; m32 = 32'd5; sgn32 = 1'b0; start32 = 1'b1;
    @(posedge clock); #1;
    start32 = 1'b0;
    e = 0;
    while (!done32 && e < 40) begin
      if (e == 4) begin start32 = 1'b1; q32 = 32'd100; m32 = 32'd100; end
      else start32 = 1'b0;
      @(posedge clock); #1;
      e++;
    end
    start32 = 1'b0;
    checks++;
    if (e !== 17) begin errors++; $display("[TB] FAIL overlap latency: got %0d expected 17", e); end
    checks++;
    if ({hi32, lo32} !== 64'd15) begin errors++; $display("[TB] FAIL overlap product: got %h_%h expected 0_f", hi32, lo32); end
    // Now in the DONE cycle: a start here must be dropped.
    start32 = 1'b1; q32 = 32'd7; m32 = 32'd7;
    @(posedge clock); #1;
    start32 = 1'b0;
    checks++;
    if ({busy32, done32} !== 2'b00) begin
      errors++; $display("[TB] FAIL start in done: got busy=%b done=%b expected 0 0", busy32, done32);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (done32 || busy32) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("[TB] FAIL ignored start activity: got %0d expected 0", pulses); end
    checks++;
    if (lo32 !== 32'd15) begin errors++; $display("[TB] FAIL product hold: got %h expected f", lo32); end
  endtask

  task automatic test_reset_abort();
    int e, b, pulses;
    repeat (2) @(posedge clock);
    @(negedge clock);
    q32 = 32'd7; m32 = 32'd9; sgn32 = 1'b0; start32 = 1'b1;
    @(posedge clock); #1;
    start32 = 1'b0;
    repeat (8) @(posedge clock);
    #3 clear_n = 1'b0;
    #1;
    checks++;
    if ({busy32, done32, hi32, lo32} !== 66'd0) begin
      errors++; $display("[TB] FAIL async abort: got busy=%b done=%b hi=%h lo=%h expected all zero", busy32, done32, hi32, lo32);
    end
    @(negedge clock);
    clear_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock); #1;
      if (done32) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("[TB] FAIL done after abort: got %0d expected 0", pulses); end
    run32(32'd2, 32'd3, 1'b0, e, b);
    checks++;
    if (e !== 17) begin errors++; $display("[TB] FAIL post-abort latency: got %0d expected 17", e); end
    checks++;
    if ({hi32, lo32} !== 64'd6) begin errors++; $display("[TB] FAIL post-abort product: got %h_%h expected 0_6", hi32, lo32); end
  endtask

  initial begin
    test_reset();
    test_signed_small();
    test_all_ones();
    test_most_negative();
    test_width8();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
Parametrised, multi-cycle radix-4 Booth (bit-pair recoding) multiplier for the CPU datapath ALU. It replaces the single-shot combinational multiply with a start/done sequential unit. The unit retires two multiplier bits per clock, supports signed and unsigned operands, and returns a 2*WIDTH-bit result split into HI/LO halves for the HI and LO registers.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4
CNT_W, $clog2(WIDTH/2+2), iteration counter width; derived, not overridden

Ports:
clock  input  1  rising-edge clock
clear_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
q  input  WIDTH  multiplier; sampled with start
m  input  WIDTH  multiplicand; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when the result is valid
product_hi  output  WIDTH  upper WIDTH bits of the product
product_lo  output  WIDTH  lower WIDTH bits of the product

Behaviour:
- Reset (clear_n=0, asynchronous, any state): state=IDLE; busy, done, product_hi, product_lo all 0; internal registers and counter cleared.
- Reset mid-operation aborts the operation. No done pulse is produced for the aborted operation.
- State machine: IDLE -> RUN -> DONE -> IDLE.
  - IDLE: on an edge with start=1, latch the operands, set busy=1, set counter=0, go to RUN. With start=0, stay in IDLE.
  - Operand extension at latch: q and m are each extended to WIDTH+2 bits. is_signed=1 sign-extends; is_signed=0 zero-extends. This lets one datapath cover both modes.
  - Iteration count K = WIDTH/2+1 (17 for WIDTH=32).
  - RUN: each edge performs one recode step on triplet {Q[1],Q[0],Q[-1]} (Q[-1] is the appended 0 bit at latch):
    - 000 or 111 -> +0
    - 001 or 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101 or 110 -> -M
  - Add into accumulator A, which is WIDTH+3 bits wide for 2M headroom. Then arithmetic-shift {A,Q,Q[-1]} right by 2 and increment the counter.
  - After the K-th RUN edge: go to DONE. product_hi/product_lo load the low 2*WIDTH bits of the combined {A,Q} result. Set done=1 and busy=0.
  - DONE: lasts exactly one cycle. done drops on the next edge and the state returns to IDLE. start during DONE is ignored.
- Latency: a start accepted at edge E0 gives done=1 in the cycle after edge E0+K. For WIDTH=32, done is visible 17 edges after the start edge. The next start is accepted no earlier than the edge after done.
- start while busy or done is high is ignored. Operands are not re-sampled and the running operation is unaffected.
- Operand changes after the start edge have no effect.
- product_hi/product_lo hold their value from the last completion until the next completion or reset. They never show intermediate values.
- Signed result is the exact two's-complement 2*WIDTH product; unsigned result is the exact unsigned product. No overflow is possible.
- Edge operands: the most-negative value (e.g. 0x80000000) and all-ones are handled exactly in both modes.

Test Plan:
- WIDTH=32, is_signed=1, q=-7 (0xFFFFFFF9), m=6 -> done exactly 17 edges after start. Result hi=0xFFFFFFFF, lo=0xFFFFFFD6. busy high for exactly 17 cycles.
- WIDTH=32, q=m=0xFFFFFFFF:
  - is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
  - is_signed=1 -> hi=0x00000000, lo=0x00000001.
- WIDTH=32, is_signed=1, q=m=0x80000000 -> hi=0x40000000, lo=0x00000000. Then q=0, m=0x12345678 -> hi=lo=0.
- WIDTH=8 instance, is_signed=1, q=0x80 (-128), m=0x7F (127) -> hi=0xC0, lo=0x80. done 5 edges after start.
- WIDTH=32, start q=3, m=5, then pulse start with q=100, m=100 mid-run -> single done pulse with lo=15, hi=0. Second request ignored. start asserted in the DONE cycle is also ignored.
- Assert clear_n=0 at iteration 8 of a run -> busy, done, hi, lo go to 0 immediately without waiting for a clock edge. No done pulse afterwards. A fresh start of 2*3 then completes with lo=6.
